// File: rtl/sound_engine.sv
// Multi-channel phase-accumulator tone generator: per-channel NCO -> shared 32x4 sine table -> averaged mix.
// Optional SOUND_ENGINE_RETRIGGER_EN: requests are always accepted and restart a playing channel.
module sound_engine #(
  parameter int CHANNELS = 2,
  parameter int NOTE_W   = 3,
  parameter int PHASE_W  = 24,
  parameter int DUR_W    = 24
) (
  input  logic                       clk50mhz,
  input  logic                       reset_n,
  input  logic [CHANNELS-1:0]        req_valid,
  output logic [CHANNELS-1:0]        req_ready,
  input  logic [CHANNELS*NOTE_W-1:0] req_note,
  input  logic [CHANNELS*DUR_W-1:0]  req_dur,
  output logic [CHANNELS-1:0]        busy,
  output logic [CHANNELS-1:0]        done,
  output logic [3:0]                 tono
);
  localparam int SHIFT = $clog2(CHANNELS);
  localparam int SUM_W = 4 + SHIFT;

  // round(2^PHASE_W / (2*L)) computed as floor((2^PHASE_W + L) / (2*L))
  function automatic logic [63:0] inc_round(input logic [63:0] half_period);
    return ((64'd1 << PHASE_W) + half_period) / (64'd2 * half_period);
  endfunction

  localparam logic [63:0] INC_C_W = inc_round(64'd2986);
  localparam logic [63:0] INC_D_W = inc_round(64'd2660);
  localparam logic [63:0] INC_E_W = inc_round(64'd2369);
  localparam logic [63:0] INC_G_W = inc_round(64'd1993);
  localparam logic [PHASE_W-1:0] INC_C = INC_C_W[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] INC_D = INC_D_W[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] INC_E = INC_E_W[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] INC_G = INC_G_W[PHASE_W-1:0];

  function automatic logic [PHASE_W-1:0] note_inc(input logic [NOTE_W-1:0] note);
    case (int'(note))
      1:       return INC_C;
      2:       return INC_D;
      3:       return INC_E;
      4:       return INC_G;
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] rom_lookup(input logic [4:0] k);
    case (k)
      5'd0, 5'd16:                return 4'd8;
      5'd1, 5'd15:                return 4'd9;
      5'd2, 5'd14:                return 4'd10;
      5'd3, 5'd13:                return 4'd12;
      5'd4, 5'd12:                return 4'd13;
      5'd5, 5'd6, 5'd10, 5'd11:   return 4'd14;
      5'd7, 5'd8, 5'd9:           return 4'd15;
      5'd17, 5'd31:               return 4'd6;
      5'd18, 5'd30:               return 4'd5;
      5'd19, 5'd29:               return 4'd3;
      5'd20, 5'd28:               return 4'd2;
      5'd21, 5'd22, 5'd26, 5'd27: return 4'd1;
      default:                    return 4'd0;
    endcase
  endfunction

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state_q   [CHANNELS];
  state_t             state_d   [CHANNELS];
  logic [PHASE_W-1:0] phase_q   [CHANNELS];
  logic [PHASE_W-1:0] phase_d   [CHANNELS];
  logic [PHASE_W-1:0] inc_q     [CHANNELS];
  logic [PHASE_W-1:0] inc_d     [CHANNELS];
  logic [DUR_W-1:0]   cnt_q     [CHANNELS];
  logic [DUR_W-1:0]   cnt_d     [CHANNELS];
  logic [3:0]         wave_p1_q [CHANNELS];
  logic [3:0]         wave_p1_d [CHANNELS];
  logic [CHANNELS-1:0] done_q;
  logic [CHANNELS-1:0] done_d;
  logic [SUM_W-1:0]    sum_p1;
  logic [3:0]          tono_p2_q;
  logic [3:0]          tono_p2_d;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
`ifdef SOUND_ENGINE_RETRIGGER_EN
      req_ready[c] = 1'b1;
`else
      req_ready[c] = (state_q[c] == IDLE);
`endif
      busy[c]    = (state_q[c] == PLAY);
      state_d[c] = state_q[c];
      phase_d[c] = '0;
      inc_d[c]   = inc_q[c];
      cnt_d[c]   = cnt_q[c];
      done_d[c]  = 1'b0;
      if (state_q[c] == PLAY) begin
        phase_d[c] = phase_q[c] + inc_q[c];
        cnt_d[c]   = cnt_q[c] - DUR_W'(1);
        if (cnt_q[c] <= DUR_W'(1)) begin
          state_d[c] = IDLE;
          phase_d[c] = '0;
          done_d[c]  = 1'b1;
        end
      end
      // An accept overrides natural completion, so a retrigger on the last cycle emits no done.
      if (req_valid[c] && req_ready[c]) begin
        state_d[c] = PLAY;
        phase_d[c] = '0;
        inc_d[c]   = note_inc(req_note[c*NOTE_W +: NOTE_W]);
        cnt_d[c]   = (req_dur[c*DUR_W +: DUR_W] == '0) ? DUR_W'(1) : req_dur[c*DUR_W +: DUR_W];
        done_d[c]  = 1'b0;
      end
      // stage 1: table lookup, idle channels sit at midscale
      wave_p1_d[c] = (state_q[c] == PLAY) ? rom_lookup(phase_q[c][PHASE_W-1 -: 5]) : 4'd8;
    end
  end

  // stage 2: average of all voices
  always_comb begin
    sum_p1 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_p1 = sum_p1 + SUM_W'(wave_p1_q[c]);
    end
    tono_p2_d = 4'(sum_p1 >> SHIFT);
  end

  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]   <= IDLE;
        phase_q[c]   <= '0;
        wave_p1_q[c] <= 4'd8;
      end
      done_q    <= '0;
      tono_p2_q <= 4'd8;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]   <= state_d[c];
        phase_q[c]   <= phase_d[c];
        wave_p1_q[c] <= wave_p1_d[c];
      end
      done_q    <= done_d;
      tono_p2_q <= tono_p2_d;
    end
  end

  always_ff @(posedge clk50mhz) begin
    for (int c = 0; c < CHANNELS; c++) begin
      inc_q[c] <= inc_d[c];
      cnt_q[c] <= cnt_d[c];
    end
  end

  assign done = done_q;
  assign tono = tono_p2_q;

endmodule

// File: tb/tb_sound_engine.sv
// Self-checking bench for sound_engine: directed scenarios plus randomized requests against
// a timestamp-based reference model (phase = cycles_played * inc, wave = sine table lookup).
module tb_sound_engine;
  localparam int CH = 2;
  localparam int NW = 3;
  localparam int PW = 24;
  localparam int DW = 24;
  localparam int SH = $clog2(CH);
`ifdef SOUND_ENGINE_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [CH-1:0]      req_valid;
  logic [CH-1:0]      req_ready;
  logic [CH*NW-1:0]   req_note;
  logic [CH*DW-1:0]   req_dur;
  logic [CH-1:0]      busy;
  logic [CH-1:0]      done;
  logic [3:0]         tono;

  sound_engine #(.CHANNELS(CH), .NOTE_W(NW), .PHASE_W(PW), .DUR_W(DW)) dut (
    .clk50mhz (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_note (req_note),
    .req_dur  (req_dur),
    .busy     (busy),
    .done     (done),
    .tono     (tono)
  );

  always #10 clk = ~clk;

  int     n_cmp = 0;
  int     n_mis = 0;
  int     cyc = 0;
  int     rom [32];
  longint inc_tab [8];
  int     st [CH];
  int     ln [CH];
  longint m_inc [CH];
  int     prev_wv [CH];
  int     exp_tono = 8;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_busy(input int c, input int n);
    return (n >= st[c]) && (n < st[c] + ln[c]);
  endfunction

  function automatic int m_wave(input int c, input int n);
    longint ph;
    ph = (longint'(n - st[c]) * m_inc[c]) % (longint'(1) << PW);
    return rom[int'(ph >> (PW - 5))];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      st[c] = 0;
      ln[c] = 0;
      m_inc[c] = 0;
      prev_wv[c] = 8;
    end
    exp_tono = 8;
  endtask

  task automatic req(input int c, input int note, input int dur);
    req_valid[c] = 1'b1;
    req_note[c*NW +: NW] = NW'(note);
    req_dur[c*DW +: DW] = DW'(dur);
  endtask

  // One clock: advance the model across the edge, then check outputs at the falling edge.
  task automatic step();
    int wv [CH];
    bit rdy [CH];
    int sum;
    logic [CH-1:0] eb, ed, er;
    @(posedge clk);
    for (int c = 0; c < CH; c++) begin
      wv[c]  = m_busy(c, cyc) ? m_wave(c, cyc) : 8;
      rdy[c] = RETRIG || !m_busy(c, cyc);
    end
    sum = 0;
    for (int c = 0; c < CH; c++) sum += prev_wv[c];
    exp_tono = sum >> SH;
    for (int c = 0; c < CH; c++) prev_wv[c] = wv[c];
    cyc++;
    for (int c = 0; c < CH; c++) begin
      if (req_valid[c] && rdy[c]) begin
        st[c] = cyc;
        ln[c] = (req_dur[c*DW +: DW] == '0) ? 1 : int'(req_dur[c*DW +: DW]);
        m_inc[c] = inc_tab[int'(req_note[c*NW +: NW])];
      end
    end
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      eb[c] = m_busy(c, cyc);
      ed[c] = (ln[c] > 0) && (cyc == st[c] + ln[c]);
      er[c] = RETRIG || !eb[c];
    end
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("req_ready", req_ready, er);
    chk("tono", tono, exp_tono);
  endtask

  task automatic async_reset();
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_tono", tono, 8);
    chk("arst_done", done, 0);
    chk("arst_ready", req_ready, {CH{1'b1}});
    model_reset();
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int Ls [4] = '{2986, 2660, 2369, 1993};
    for (int k = 0; k < 32; k++)
      rom[k] = int'($floor(7.5 + 7.5 * $sin(2.0 * 3.141592653589793 * k / 32.0) + 0.5));
    for (int i = 0; i < 8; i++) inc_tab[i] = 0;
    for (int i = 1; i <= 4; i++)
      inc_tab[i] = longint'($floor((2.0 ** PW) / (2.0 * Ls[i-1]) + 0.5));
    req_valid = '0;
    req_note = '0;
    req_dur = '0;
    model_reset();

    #2 reset_n = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_tono", tono, 8);
    chk("rst_done", done, 0);
    chk("rst_ready", req_ready, 2'b11);
    @(negedge clk);
    #5 reset_n = 1'b1;
    repeat (10) step();

    // Single long note: 1000 PLAY cycles, done after, last table sample is rom[5]
    req(0, 1, 1000);
    step();
    req_valid = '0;
    cnt = int'(busy[0]);
    repeat (999) begin
      step();
      cnt += int'(busy[0]);
    end
    chk("long_busy_cycles", cnt, 1000);
    step();
    chk("long_done", done[0], 1);
    step();
    chk("long_tono_rom5", tono, 11);
    repeat (3) step();

    // Simultaneous note and rest on both channels
    req(0, 4, 200);
    req(1, 0, 200);
    step();
    req_valid = '0;
    chk("dual_busy_start", busy, 2'b11);
    repeat (199) step();
    chk("dual_busy_end", busy, 2'b11);
    step();
    chk("dual_done", done, 2'b11);
    repeat (3) step();

    // Zero duration, then back-to-back request in the done cycle
    req(0, 2, 0);
    step();
    req_valid = '0;
    chk("dur0_busy", busy[0], 1);
    step();
    chk("dur0_done", done[0], 1);
    chk("dur0_idle", busy[0], 0);
    req(0, 3, 5);
    step();
    req_valid = '0;
    chk("b2b_busy", busy[0], 1);
    repeat (8) step();

    // Second request while playing
    req(0, 1, 50);
    step();
    req_valid = '0;
    repeat (5) step();
    req(0, 4, 10);
    chk("play_req_ready", req_ready[0], RETRIG ? 1 : 0);
    step();
    req_valid = '0;
    repeat (60) step();

    // Asynchronous reset in the middle of notes, then replay from phase 0
    req(0, 3, 100);
    req(1, 4, 100);
    step();
    req_valid = '0;
    repeat (20) step();
    async_reset();
    repeat (3) step();
    req(0, 1, 30);
    step();
    req_valid = '0;
    repeat (40) step();

    // Randomized traffic
    repeat (4000) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0)
          req(c, int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 30)));
        else
          req_valid[c] = 1'b0;
      end
      step();
      if ($urandom_range(0, 999) == 0) async_reset();
    end
    req_valid = '0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
